load_store_unit: RTL and testbench

Multi-cycle data-memory access unit for the RISC-V core. It sits between the ALU/register-file outputs and the external data-memory bus, directly upstream of the result mux. It turns load/store requests into a ready/valid bus transaction and stalls the core until the access completes. For loads, it returns byte/halfword/word data to the result mux as `ReadData`, already aligned and sign- or zero-extended.

---
 rtl/load_store_unit.sv | 159 +++++++++++++++
 tb/tb_load_store_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// load_store_unit: multi-cycle load/store bridge between the core and a ready/valid data bus.
// Stalls the core during an access and returns aligned, extended load data.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        AccessFault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic        acc, legal, complete, timeout;
  logic [7:0]  cnt;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        fault_q;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] shifted, load_val;

  assign acc      = MemRead | MemWrite;
  assign complete = (state == BUSY) & mem_ready;
  assign timeout  = (state == BUSY) & ~mem_ready & (cnt == TIMEOUT_LAST);

  // A store with BU/HU encoding is illegal even though the same encoding is a valid load.
  always_comb begin
    legal = 1'b0;
    case (funct3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~ALUResult[0];
      3'b010:  legal = (ALUResult[1:0] == 2'b00);
      3'b100:  legal = ~MemWrite;
      3'b101:  legal = ~MemWrite & ~ALUResult[0];
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = WriteData;
    if (MemWrite) begin
      case (funct3)
        3'b000: begin
          be_next    = 4'b0001 << ALUResult[1:0];
          wdata_next = {4{WriteData[7:0]}};
        end
        3'b001: begin
          be_next    = ALUResult[1] ? 4'b1100 : 4'b0011;
          wdata_next = {2{WriteData[15:0]}};
        end
        default: begin
          be_next    = 4'b1111;
          wdata_next = WriteData;
        end
      endcase
    end
  end

  always_comb begin
    shifted  = mem_rdata >> {off_q, 3'b000};
    load_val = shifted;
    case (f3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'b0, shifted[7:0]};
      3'b101:  load_val = {16'b0, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (acc && legal) state_next = BUSY;
      BUSY:    if (complete || timeout) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign Stall       = ~reset & (((state == IDLE) & acc & legal) | (state == BUSY));
  assign AccessFault = ~reset & (((state == IDLE) & acc & ~legal) | fault_q);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'b0;
      mem_be    <= 4'b0;
      mem_wdata <= 32'b0;
      ReadData  <= 32'b0;
      cnt       <= 8'b0;
      f3_q      <= 3'b0;
      off_q     <= 2'b0;
      fault_q   <= 1'b0;
    end else begin
      fault_q <= 1'b0;
      case (state)
        IDLE: begin
          if (acc && legal) begin
            mem_req   <= 1'b1;
            mem_we    <= MemWrite;
            mem_addr  <= {ALUResult[31:2], 2'b00};
            mem_be    <= be_next;
            mem_wdata <= wdata_next;
            f3_q      <= funct3;
            off_q     <= ALUResult[1:0];
            cnt       <= 8'b0;
          end else if (acc) begin
            ReadData <= 32'b0;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (!mem_we) ReadData <= load_val;
          end else if (timeout) begin
            mem_req  <= 1'b0;
            ReadData <= 32'b0;
            fault_q  <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// Testbench for load_store_unit: table of accesses with a result scoreboard, plus reset sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] ALUResult, WriteData, ReadData;
  logic        Stall, AccessFault;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int errors = 0;
  int checks = 0;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .funct3(funct3), .ALUResult(ALUResult), .WriteData(WriteData),
    .ReadData(ReadData), .Stall(Stall), .AccessFault(AccessFault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld, st;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;
    int          waitc;
    logic        fault_now, tmo;
    logic [31:0] exp_rd;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    int          exp_stalls;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        fault;
    int          stalls;
  } sb_t;

  sb_t  sbq[$];
  vec_t vecs[17];

  function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int waitc,
                              input logic fnow, input logic tmo, input logic [31:0] rd,
                              input logic [3:0] be, input logic [31:0] ewd, input int stalls);
    vec_t v;
    v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.waitc = waitc; v.fault_now = fnow; v.tmo = tmo; v.exp_rd = rd; v.exp_be = be;
    v.exp_wdata = ewd; v.exp_stalls = stalls;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'b000;
    ALUResult = 32'h0; WriteData = 32'h0; mem_ready = 1'b0;
  endtask

  task automatic run(input vec_t v, input int idx);
    sb_t e, got;
    int  busy;
    bit  done;
    @(negedge clk);
    MemRead = v.ld; MemWrite = v.st; funct3 = v.f3; ALUResult = v.addr;
    WriteData = v.wdata; mem_rdata = v.rdata; mem_ready = 1'b0;
    e.rd = v.exp_rd; e.fault = v.fault_now | v.tmo; e.stalls = v.exp_stalls;
    sbq.push_back(e);
    #1;
    got.stalls = Stall ? 1 : 0;
    got.rd = 32'h0; got.fault = 1'b0;
    if (v.fault_now) begin
      got.fault = AccessFault;
      @(negedge clk);
      drive_idle();
      #1;
      chk($sformatf("v%0d_no_req", idx), {31'b0, mem_req}, 32'h0);
      chk($sformatf("v%0d_fault_pulse_end", idx), {31'b0, AccessFault}, 32'h0);
      got.rd = ReadData;
    end else begin
      busy = 0;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
        @(negedge clk);
        #1;
        if (mem_req) begin
          chk($sformatf("v%0d_addr", idx), mem_addr, {v.addr[31:2], 2'b00});
          chk($sformatf("v%0d_be", idx), {28'b0, mem_be}, {28'b0, v.exp_be});
          chk($sformatf("v%0d_we", idx), {31'b0, mem_we}, {31'b0, v.st});
          if (v.st) chk($sformatf("v%0d_wdata", idx), mem_wdata, v.exp_wdata);
          if (Stall) got.stalls++;
          mem_ready = (busy >= v.waitc);
          busy++;
        end else if (!Stall) begin
          done = 1'b1;
          got.rd = ReadData;
          got.fault = AccessFault;
          drive_idle();
        end else begin
          got.stalls++;
        end
      end
      if (!done) begin
        errors++;
        $display("FAIL v%0d_complete: got no DONE cycle expected one within 40 cycles", idx);
        drive_idle();
      end
    end
    e = sbq.pop_front();
    chk($sformatf("v%0d_readdata", idx), got.rd, e.rd);
    chk($sformatf("v%0d_fault", idx), {31'b0, got.fault}, {31'b0, e.fault});
    chk($sformatf("v%0d_stalls", idx), got.stalls, e.stalls);
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    mem_rdata = 32'h0;
    vecs[0]  = mk(1,0,3'b000,32'h103,32'h0,32'h80FF1234,0,0,0,32'hFFFFFF80,4'hF,32'h0,2);
    vecs[1]  = mk(1,0,3'b101,32'h102,32'h0,32'h9ABC0000,3,0,0,32'h00009ABC,4'hF,32'h0,5);
    vecs[2]  = mk(0,1,3'b000,32'h201,32'hA5,32'h0,0,0,0,32'h00009ABC,4'b0010,32'hA5A5A5A5,2);
    vecs[3]  = mk(1,0,3'b010,32'h102,32'h0,32'h0,0,1,0,32'h0,4'h0,32'h0,0);
    vecs[4]  = mk(1,0,3'b001,32'h002,32'h0,32'h80010000,1,0,0,32'hFFFF8001,4'hF,32'h0,3);
    vecs[5]  = mk(0,1,3'b001,32'h006,32'h12345678,32'h0,0,0,0,32'hFFFF8001,4'b1100,32'h56785678,2);
    vecs[6]  = mk(0,1,3'b010,32'h008,32'hDEADBEEF,32'h0,2,0,0,32'hFFFF8001,4'hF,32'hDEADBEEF,4);
    vecs[7]  = mk(0,1,3'b100,32'h000,32'h0,32'h0,0,1,0,32'h0,4'h0,32'h0,0);
    vecs[8]  = mk(1,0,3'b100,32'h001,32'h0,32'h0000F100,0,0,0,32'h000000F1,4'hF,32'h0,2);
    vecs[9]  = mk(1,0,3'b010,32'h00C,32'h0,32'hCAFEBABE,2,0,0,32'hCAFEBABE,4'hF,32'h0,4);
    vecs[10] = mk(1,0,3'b011,32'h000,32'h0,32'h0,0,1,0,32'h0,4'h0,32'h0,0);
    vecs[11] = mk(1,0,3'b000,32'h000,32'h0,32'h0000007F,0,0,0,32'h0000007F,4'hF,32'h0,2);
    vecs[12] = mk(1,0,3'b101,32'h101,32'h0,32'h0,0,1,0,32'h0,4'h0,32'h0,0);
    vecs[13] = mk(1,0,3'b000,32'h002,32'h0,32'h00AA0000,0,0,0,32'hFFFFFFAA,4'hF,32'h0,2);
    vecs[14] = mk(1,0,3'b010,32'h010,32'h0,32'h11111111,1000,0,1,32'h0,4'hF,32'h0,5);
    vecs[15] = mk(1,1,3'b000,32'h305,32'h3C,32'h0,0,0,0,32'h0,4'b0010,32'h3C3C3C3C,2);
    vecs[16] = mk(1,0,3'b010,32'h030,32'h0,32'h12345678,1,0,0,32'h12345678,4'hF,32'h0,3);

    // Reset state, with a pending load that must not raise Stall while reset is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    MemRead = 1'b1;
    #1;
    chk("rst_stall", {31'b0, Stall}, 32'h0);
    chk("rst_fault", {31'b0, AccessFault}, 32'h0);
    chk("rst_req", {31'b0, mem_req}, 32'h0);
    chk("rst_readdata", ReadData, 32'h0);
    chk("rst_be", {28'b0, mem_be}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    MemRead = 1'b0;
    reset = 1'b0;

    for (int i = 0; i < 17; i++) run(vecs[i], i);

    // Reset during BUSY abandons the access and clears every output.
    @(negedge clk);
    MemRead = 1'b1; funct3 = 3'b010; ALUResult = 32'h20; mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("busy_req_before_reset", {31'b0, mem_req}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("busy_rst_req", {31'b0, mem_req}, 32'h0);
    chk("busy_rst_stall", {31'b0, Stall}, 32'h0);
    chk("busy_rst_fault", {31'b0, AccessFault}, 32'h0);
    chk("busy_rst_readdata", ReadData, 32'h0);
    chk("busy_rst_addr", mem_addr, 32'h0);
    chk("busy_rst_be", {28'b0, mem_be}, 32'h0);
    chk("busy_rst_wdata", mem_wdata, 32'h0);
    reset = 1'b0;
    drive_idle();
    @(negedge clk);
    #1;
    chk("post_rst_idle_req", {31'b0, mem_req}, 32'h0);
    chk("post_rst_idle_stall", {31'b0, Stall}, 32'h0);

    run(mk(1,0,3'b001,32'h002,32'h0,32'h7FFF0000,0,0,0,32'h00007FFF,4'hF,32'h0,2), 17);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
